player_sprite_pixel_pipe: RTL and testbench

//  Downstream of the player animation stage: takes its per-pixel playerOn flag and spriteAddress,

---
 rtl/player_sprite_pixel_pipe.sv | 181 ++++++++++++++++++
 tb/tb_player_sprite_pixel_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/player_sprite_pixel_pipe.sv
// Player sprite pixel pipeline: sprite ROM fetch, 16-entry palette decode,
// transparency and hit-flash blanking, with coordinates kept aligned to RGB.
// Latency from playerOn/spriteAddress/DrawX/DrawY to outputs is ROM_LAT+2 Clk.
// Optional feature: define PLAYER_HIT_FLASH_EN to build the hit-flash sequencer;
// without it hit/frameStart are ignored and the player is never blanked.
//
// Flash sequencer states:
//   state      | meaning
//   IDLE       | no flash in progress, sprite drawn normally
//   HIDDEN     | flash active, sprite pixels suppressed this half-period
//   VISIBLE    | flash active, sprite pixels drawn this half-period
module player_sprite_pixel_pipe #(
  parameter int         ADDR_W          = 21,
  parameter int         IDX_W           = 4,
  parameter int         ROM_LAT         = 2,
  parameter int         TRANSPARENT_IDX = 0,
  parameter logic [7:0] FLASH_FRAMES    = 8'd60,
  parameter logic [7:0] FLASH_PERIOD    = 8'd4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              playerOn,
  input  logic [ADDR_W-1:0] spriteAddress,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frameStart,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic              pixelValid,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic [9:0]        DrawX_o,
  output logic [9:0]        DrawY_o,
  output logic              flashing
);

  logic hide;

`ifdef PLAYER_HIT_FLASH_EN
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HIDDEN  = 2'd1;
  localparam logic [1:0] ST_VISIBLE = 2'd2;

  logic [1:0] flashState;
  logic [7:0] framesLeft;
  logic [7:0] phase;

  // Flash sequencer: hit (re)starts the blink; frameStart counts frames down
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flashState <= ST_IDLE;
      framesLeft <= 8'd0;
      phase      <= 8'd0;
    end else if (hit) begin
      flashState <= ST_HIDDEN;
      framesLeft <= FLASH_FRAMES;
      phase      <= FLASH_PERIOD;
    end else if (frameStart && (flashState != ST_IDLE)) begin
      framesLeft <= framesLeft - 8'd1;
      if (framesLeft == 8'd1) begin
        // running out of frames wins over a coincident half-period toggle
        flashState <= ST_IDLE;
        phase      <= 8'd0;
      end else if (phase == 8'd1) begin
        flashState <= (flashState == ST_HIDDEN) ? ST_VISIBLE : ST_HIDDEN;
        phase      <= FLASH_PERIOD;
      end else begin
        phase <= phase - 8'd1;
      end
    end
  end

  assign hide     = (flashState == ST_HIDDEN);
  assign flashing = (flashState != ST_IDLE);
`else
  logic [17:0] unusedFlashIn;
  assign unusedFlashIn = {hit, frameStart, FLASH_FRAMES, FLASH_PERIOD};
  assign hide          = 1'b0;
  assign flashing      = 1'b0;
`endif

  logic       onA;
  logic       hideA;
  logic [9:0] xA;
  logic [9:0] yA;

  // Stage A: launch ROM address and capture pixel context (hide sampled here)
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      onA      <= 1'b0;
      hideA    <= 1'b0;
      xA       <= 10'd0;
      yA       <= 10'd0;
    end else begin
      if (playerOn) rom_addr <= spriteAddress;
      onA   <= playerOn;
      hideA <= hide;
      xA    <= DrawX;
      yA    <= DrawY;
    end
  end

  logic       onB   [ROM_LAT];
  logic       hideB [ROM_LAT];
  logic [9:0] xB    [ROM_LAT];
  logic [9:0] yB    [ROM_LAT];

  // Stage B: delay pixel context by the ROM latency so it meets rom_data
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        onB[i]   <= 1'b0;
        hideB[i] <= 1'b0;
        xB[i]    <= 10'd0;
        yB[i]    <= 10'd0;
      end
    end else begin
      onB[0]   <= onA;
      hideB[0] <= hideA;
      xB[0]    <= xA;
      yB[0]    <= yA;
      for (int i = 1; i < ROM_LAT; i++) begin
        onB[i]   <= onB[i-1];
        hideB[i] <= hideB[i-1];
        xB[i]    <= xB[i-1];
        yB[i]    <= yB[i-1];
      end
    end
  end

  function automatic logic [23:0] paletteLookup(input logic [IDX_W-1:0] idx);
    logic [23:0] rgb;
    case (32'(idx))
      0:       rgb = 24'h000000;
      1:       rgb = 24'hFFFFFF;
      2:       rgb = 24'hFF0000;
      3:       rgb = 24'h00FF00;
      4:       rgb = 24'h0000FF;
      5:       rgb = 24'hFFD700;
      6:       rgb = 24'h8B4513;
      7:       rgb = 24'hFFA500;
      8:       rgb = 24'h808080;
      9:       rgb = 24'hC0C0C0;
      10:      rgb = 24'h00FFFF;
      11:      rgb = 24'h800080;
      12:      rgb = 24'hFFC0CB;
      13:      rgb = 24'h006400;
      14:      rgb = 24'h202020;
      15:      rgb = 24'hF5DEB3;
      default: rgb = 24'hFF00FF; // out-of-table index: loud magenta for debug
    endcase
    return rgb;
  endfunction

  logic        opaque;
  logic [23:0] palRgb;

  assign palRgb = paletteLookup(rom_data);
  assign opaque = onB[ROM_LAT-1] && (rom_data != IDX_W'(TRANSPARENT_IDX)) && !hideB[ROM_LAT-1];

  // Stage C: register decoded colour; colour is forced black when not drawn
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixelValid <= 1'b0;
      Red        <= 8'd0;
      Green      <= 8'd0;
      Blue       <= 8'd0;
      DrawX_o    <= 10'd0;
      DrawY_o    <= 10'd0;
    end else begin
      pixelValid         <= opaque;
      {Red, Green, Blue} <= opaque ? palRgb : 24'h000000;
      DrawX_o            <= xB[ROM_LAT-1];
      DrawY_o            <= yB[ROM_LAT-1];
    end
  end

endmodule

// File: tb/tb_player_sprite_pixel_pipe.sv
// Bench for player_sprite_pixel_pipe: directed scenarios plus random traffic,
// checked against a per-pixel expectation queue and a frames-since-hit flash model.
module tb_player_sprite_pixel_pipe;

  localparam int         ROM_LAT = 2;
  localparam int         L       = ROM_LAT + 2;
  localparam logic [7:0] FF      = 8'd8;
  localparam logic [7:0] FP      = 8'd2;
`ifdef PLAYER_HIT_FLASH_EN
  localparam bit flashEn = 1'b1;
`else
  localparam bit flashEn = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        playerOn;
  logic [20:0] spriteAddress;
  logic [9:0]  DrawX, DrawY;
  logic        frameStart, hit;
  logic [20:0] rom_addr;
  logic [3:0]  rom_data;
  logic        pixelValid;
  logic [7:0]  Red, Green, Blue;
  logic [9:0]  DrawX_o, DrawY_o;
  logic        flashing;

  player_sprite_pixel_pipe #(
    .ADDR_W(21), .IDX_W(4), .ROM_LAT(ROM_LAT), .TRANSPARENT_IDX(0),
    .FLASH_FRAMES(FF), .FLASH_PERIOD(FP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .playerOn(playerOn), .spriteAddress(spriteAddress),
    .DrawX(DrawX), .DrawY(DrawY), .frameStart(frameStart), .hit(hit),
    .rom_addr(rom_addr), .rom_data(rom_data), .pixelValid(pixelValid),
    .Red(Red), .Green(Green), .Blue(Blue), .DrawX_o(DrawX_o), .DrawY_o(DrawY_o),
    .flashing(flashing)
  );

  always #5 Clk = ~Clk;

  // Sprite content: address 100 holds index 5, everything else its low nibble
  function automatic logic [3:0] romIdx(input logic [20:0] a);
    if (a == 21'd100) return 4'd5;
    return a[3:0];
  endfunction

  // ROM model with ROM_LAT cycles from rom_addr to rom_data
  logic [3:0] romPipe [ROM_LAT];
  always @(posedge Clk) begin
    romPipe[0] <= romIdx(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign rom_data = romPipe[ROM_LAT-1];

  logic [23:0] pal [16] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                            24'h0000FF, 24'hFFD700, 24'h8B4513, 24'hFFA500,
                            24'h808080, 24'hC0C0C0, 24'h00FFFF, 24'h800080,
                            24'hFFC0CB, 24'h006400, 24'h202020, 24'hF5DEB3};

  typedef struct {
    logic        v;
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [9:0]  y;
  } rec_t;

  rec_t        expQ [$];
  int          nChecks = 0;
  int          nFail   = 0;
  bit          mActive;
  int          mN;
  logic [20:0] mAddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    rec_t z;
    z.v = 1'b0; z.rgb = 24'h0; z.x = 10'd0; z.y = 10'd0;
    expQ.delete();
    for (int i = 0; i < L - 1; i++) expQ.push_back(z);
    mActive = 1'b0;
    mN      = 0;
    mAddr   = 21'd0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".valid"}, {31'd0, pixelValid}, 32'd0);
    check({tag, ".rgb"}, {8'd0, Red, Green, Blue}, 32'd0);
    check({tag, ".x"}, {22'd0, DrawX_o}, 32'd0);
    check({tag, ".y"}, {22'd0, DrawY_o}, 32'd0);
    check({tag, ".flashing"}, {31'd0, flashing}, 32'd0);
    check({tag, ".rom_addr"}, {11'd0, rom_addr}, 32'd0);
  endtask

  // One pixel clock: drive inputs, predict, then compare L-1 edges later
  task automatic cyc(input logic on, input logic [20:0] addr, input logic [9:0] x,
                     input logic [9:0] y, input logic fs, input logic ht);
    rec_t r;
    logic hideNow;
    playerOn = on; spriteAddress = addr; DrawX = x; DrawY = y; frameStart = fs; hit = ht;
    hideNow = flashEn && mActive && (((mN / int'(FP)) % 2) == 0);
    r.v   = on && (romIdx(addr) != 4'd0) && !hideNow;
    r.rgb = r.v ? pal[romIdx(addr)] : 24'h0;
    r.x   = x;
    r.y   = y;
    expQ.push_back(r);
    if (on) mAddr = addr;
    if (flashEn) begin
      if (ht) begin
        mActive = 1'b1;
        mN      = 0;
      end else if (fs && mActive) begin
        mN++;
        if (mN >= int'(FF)) mActive = 1'b0;
      end
    end
    @(posedge Clk);
    #1;
    r = expQ.pop_front();
    check("pixelValid", {31'd0, pixelValid}, {31'd0, r.v});
    check("rgb", {8'd0, Red, Green, Blue}, {8'd0, r.rgb});
    check("DrawX_o", {22'd0, DrawX_o}, {22'd0, r.x});
    check("DrawY_o", {22'd0, DrawY_o}, {22'd0, r.y});
    check("flashing", {31'd0, flashing}, {31'd0, mActive});
    check("rom_addr", {11'd0, rom_addr}, {11'd0, mAddr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 21'd0, 10'd0, 10'd0, 1'b0, 1'b0);
  endtask

  // A few frames of opaque pixels; frameStart on the last cycle of each frame
  task automatic frames(input int n, input int base);
    for (int f = 0; f < n; f++) begin
      for (int p = 0; p < 3; p++)
        cyc(1'b1, 21'((base + f) * 16 + p + 1), 10'(f * 4 + p), 10'(base), 1'b0, 1'b0);
      cyc(1'b1, 21'((base + f) * 16 + 7), 10'(f * 4 + 3), 10'(base), 1'b1, 1'b0);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    playerOn = 1'b0; spriteAddress = 21'd0; DrawX = 10'd0; DrawY = 10'd0;
    frameStart = 1'b0; hit = 1'b0;
    repeat (3) @(negedge Clk);
    checkAllZero("reset");
    Reset_n = 1'b1;
    modelReset();

    // sprite pixel at address 100 -> palette[5] four clocks later
    cyc(1'b1, 21'd100, 10'd321, 10'd123, 1'b0, 1'b0);
    idle(4);
    // transparent index with playerOn high
    cyc(1'b1, 21'd32, 10'd12, 10'd34, 1'b0, 1'b0);
    idle(4);
    // on/off pattern 1,0,1,1,0 with distinct addresses
    cyc(1'b1, 21'd101, 10'd1, 10'd9, 1'b0, 1'b0);
    cyc(1'b0, 21'd102, 10'd2, 10'd9, 1'b0, 1'b0);
    cyc(1'b1, 21'd103, 10'd3, 10'd9, 1'b0, 1'b0);
    cyc(1'b1, 21'd104, 10'd4, 10'd9, 1'b0, 1'b0);
    cyc(1'b0, 21'd105, 10'd5, 10'd9, 1'b0, 1'b0);
    idle(4);

    // reset mid-stream of playerOn=1, then first pixel traverses the full pipe
    for (int i = 0; i < 3; i++) cyc(1'b1, 21'(200 + i), 10'(i), 10'd7, 1'b0, 1'b0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge Clk);
    playerOn = 1'b0;
    Reset_n = 1'b1;
    modelReset();
    idle(2);
    cyc(1'b1, 21'd100, 10'd55, 10'd66, 1'b0, 1'b0);
    idle(4);

    // hit-flash: full sequence, then a restart at frame 5
    cyc(1'b0, 21'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    frames(10, 1);
    cyc(1'b0, 21'd0, 10'd0, 10'd0, 1'b0, 1'b1);
    frames(5, 20);
    cyc(1'b1, 21'd401, 10'd0, 10'd0, 1'b0, 1'b1);
    frames(10, 40);
    // hit and frameStart in the same cycle: hit wins
    frames(2, 60);
    cyc(1'b1, 21'd993, 10'd1, 10'd1, 1'b1, 1'b1);
    frames(3, 70);

    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), 21'($urandom), 10'($urandom), 10'($urandom),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 120) == 0));
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
